// File: rtl/fpu_addsub_stage_pkg.sv
// rtl/fpu_addsub_stage_pkg.sv - shared FPU class enum, binary32 constants and fflags bit positions
package fpu_addsub_stage_pkg;

  typedef enum logic [1:0] {
    CLS_NONE     = 2'd0,
    CLS_QNAN_OUT = 2'd1,
    CLS_INF_OUT  = 2'd2
  } fp_class_e;

  localparam logic [31:0] FP32_CANON_NAN = 32'h7fc00000;
  localparam logic [7:0]  FP32_EXP_MAX   = 8'hff;

  localparam logic [2:0] FFLAG_NV = 3'd4;
  localparam logic [2:0] FFLAG_DZ = 3'd3;
  localparam logic [2:0] FFLAG_OF = 3'd2;
  localparam logic [2:0] FFLAG_UF = 3'd1;
  localparam logic [2:0] FFLAG_NX = 3'd0;

  // Add/sub here can only raise invalid or inexact; the other bits are always clear.
  function automatic logic [4:0] make_fflags(input logic nv, input logic nx);
    logic [4:0] f;
    f           = '0;
    f[FFLAG_NV] = nv;
    f[FFLAG_DZ] = 1'b0;
    f[FFLAG_OF] = 1'b0;
    f[FFLAG_UF] = 1'b0;
    f[FFLAG_NX] = nx;
    return f;
  endfunction

  function automatic logic [31:0] fp32_inf(input logic sign);
    return {sign, FP32_EXP_MAX, 23'h0};
  endfunction

endpackage

// File: rtl/fpu_addsub_stage_if.sv
// rtl/fpu_addsub_stage_if.sv - request and writeback handshake bundle for the add/sub stage
interface fpu_addsub_stage_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;

  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [4:0]  wb_flags;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rd, wb_ready,
    input  req_ready, wb_valid, wb_data, wb_rd, wb_flags
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd, wb_ready,
    output req_ready, wb_valid, wb_data, wb_rd, wb_flags
  );

endinterface

// File: rtl/fpu_addsub_stage_classify.sv
// rtl/fpu_addsub_stage_classify.sv - fp32_classify: combinational binary32 operand classifier
module fp32_classify
  import fpu_addsub_stage_pkg::*;
(
  input  logic [31:0] op,
  output logic        is_zero,
  output logic        is_sub,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan
);

  logic exp_zero;
  logic exp_max;
  logic frac_zero;
  logic unused_sign;

  assign exp_zero  = (op[30:23] == 8'h00);
  assign exp_max   = (op[30:23] == FP32_EXP_MAX);
  assign frac_zero = (op[22:0] == 23'h0);

  assign is_zero = exp_zero & frac_zero;
  assign is_sub  = exp_zero & ~frac_zero;
  assign is_inf  = exp_max & frac_zero;
  assign is_nan  = exp_max & ~frac_zero;
  // Quiet bit clear on a NaN marks it signaling.
  assign is_snan = is_nan & ~op[22];

  assign unused_sign = op[31];

endmodule

// File: rtl/fpu_addsub_stage.sv
// rtl/fpu_addsub_stage.sv - FADD/FSUB issue/writeback wrapper around FADD_F; FPU_FFLAGS_ACC_EN enables sticky fflags
module fpu_addsub_stage
  import fpu_addsub_stage_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTn,
  fpu_addsub_stage_if.slave  bus,
  output logic [31:0]        fadd_in1,
  output logic [31:0]        fadd_in2,
  input  logic [31:0]        fadd_out,
  input  logic               fadd_inexact,
  input  logic               fflags_clr,
  output logic [4:0]         fflags_acc
);

  // S1: operand register feeding the adder
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_a_q,     s1_a_d;
  logic [31:0] s1_b_q,     s1_b_d;
  logic [4:0]  s1_rd_q,    s1_rd_d;
  fp_class_e   s1_cls_q,   s1_cls_d;
  // NV for a NaN result, sign for an infinite result
  logic        s1_aux_q,   s1_aux_d;

  // S2: writeback register
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] wb_data_q,  wb_data_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  logic [4:0]  wb_flags_q, wb_flags_d;

  logic        s2_adv;
  logic        s1_adv;
  logic        req_ready;
  logic        accept;
  logic        retire;

  logic [31:0] rs2_signed;
  logic        a_zero, a_sub, a_inf, a_nan, a_snan;
  logic        b_zero, b_sub, b_inf, b_nan, b_snan;
  fp_class_e   scr_cls;
  logic        scr_aux;
  logic        unused_zero;

  assign s2_adv    = ~s2_valid_q | bus.wb_ready;
  assign s1_adv    = s1_valid_q & s2_adv;
  assign req_ready = ~s1_valid_q | s2_adv;
  assign accept    = bus.req_valid & req_ready;
  assign retire    = s2_valid_q & bus.wb_ready;

  // Subtraction is addition with the second operand's sign flipped.
  assign rs2_signed = bus.req_op ? {~bus.req_rs2[31], bus.req_rs2[30:0]} : bus.req_rs2;

  fp32_classify u_cls_a (
    .op      (bus.req_rs1),
    .is_zero (a_zero),
    .is_sub  (a_sub),
    .is_inf  (a_inf),
    .is_nan  (a_nan),
    .is_snan (a_snan)
  );

  fp32_classify u_cls_b (
    .op      (rs2_signed),
    .is_zero (b_zero),
    .is_sub  (b_sub),
    .is_inf  (b_inf),
    .is_nan  (b_nan),
    .is_snan (b_snan)
  );

  assign unused_zero = a_zero ^ b_zero;

  // Screen the cases the adder cannot handle: NaN wins, then opposing infinities, then any infinity.
  always_comb begin
    scr_cls = CLS_NONE;
    scr_aux = 1'b0;
    if (a_nan | b_nan) begin
      scr_cls = CLS_QNAN_OUT;
      scr_aux = a_snan | b_snan;
    end else if (a_inf & b_inf & (bus.req_rs1[31] != rs2_signed[31])) begin
      scr_cls = CLS_QNAN_OUT;
      scr_aux = 1'b1;
    end else if (a_inf) begin
      scr_cls = CLS_INF_OUT;
      scr_aux = bus.req_rs1[31];
    end else if (b_inf) begin
      scr_cls = CLS_INF_OUT;
      scr_aux = rs2_signed[31];
    end
  end

  // S1 next state: load on accept (subnormals flushed to signed zero), empty when it moves to S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_rd_d    = s1_rd_q;
    s1_cls_d   = s1_cls_q;
    s1_aux_d   = s1_aux_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_sub ? {bus.req_rs1[31], 31'h0} : bus.req_rs1;
      s1_b_d     = b_sub ? {rs2_signed[31], 31'h0} : rs2_signed;
      s1_rd_d    = bus.req_rd;
      s1_cls_d   = scr_cls;
      s1_aux_d   = scr_aux;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 next state: capture adder result or screened value; hold while stalled, empty on retire.
  always_comb begin
    s2_valid_d = s2_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_flags_d = wb_flags_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      wb_rd_d    = s1_rd_q;
      case (s1_cls_q)
        CLS_QNAN_OUT: begin
          wb_data_d  = FP32_CANON_NAN;
          wb_flags_d = make_fflags(s1_aux_q, 1'b0);
        end
        CLS_INF_OUT: begin
          wb_data_d  = fp32_inf(s1_aux_q);
          wb_flags_d = make_fflags(1'b0, 1'b0);
        end
        default: begin
          // Tiny adder results are flushed to signed zero, keeping only the sign.
          wb_data_d  = (fadd_out[30:23] == 8'h00) ? {fadd_out[31], 31'h0} : fadd_out;
          wb_flags_d = make_fflags(1'b0, fadd_inexact);
        end
      endcase
    end else if (retire) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_rd_q    <= '0;
      s1_cls_q   <= CLS_NONE;
      s1_aux_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_rd_q    <= s1_rd_d;
      s1_cls_q   <= s1_cls_d;
      s1_aux_q   <= s1_aux_d;
      s2_valid_q <= s2_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_flags_q <= wb_flags_d;
    end
  end

`ifdef FPU_FFLAGS_ACC_EN
  logic [4:0] fflags_acc_q, fflags_acc_d;

  // Sticky flags; a clear wins over a retire in the same cycle, dropping that op's flags.
  always_comb begin
    fflags_acc_d = fflags_acc_q;
    if (fflags_clr) begin
      fflags_acc_d = '0;
    end else if (retire) begin
      fflags_acc_d = fflags_acc_q | wb_flags_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fflags_acc_q <= '0;
    end else begin
      fflags_acc_q <= fflags_acc_d;
    end
  end

  assign fflags_acc = fflags_acc_q;
`else
  logic unused_clr;
  assign unused_clr = fflags_clr;
  assign fflags_acc = '0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.wb_valid  = s2_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_flags  = wb_flags_q;
  assign fadd_in1      = s1_a_q;
  assign fadd_in2      = s1_b_q;

endmodule

// File: tb/tb_fpu_addsub_stage.sv
// tb/tb_fpu_addsub_stage.sv - self-checking bench for fpu_addsub_stage with a stand-in adder and reference model
module tb_fpu_addsub_stage;

`ifdef FPU_FFLAGS_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic        CLK;
  logic        RSTn;
  logic [31:0] fadd_in1;
  logic [31:0] fadd_in2;
  logic [31:0] fadd_out;
  logic        fadd_inexact;
  logic        fflags_clr;
  logic [4:0]  fflags_acc;

  fpu_addsub_stage_if bus ();

  fpu_addsub_stage dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .bus          (bus),
    .fadd_in1     (fadd_in1),
    .fadd_in2     (fadd_in2),
    .fadd_out     (fadd_out),
    .fadd_inexact (fadd_inexact),
    .fflags_clr   (fflags_clr),
    .fflags_acc   (fflags_acc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_ret = 0;
  bit rand_en = 1'b0;

  logic [41:0] exp_q[$];   // {flags, data, rd}
  logic [41:0] mon_e;
  logic [4:0]  acc_m = '0;
  logic [4:0]  ret_f;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Stand-in for FADD_F: exact answers for the named cases, an arbitrary deterministic mix otherwise.
  function automatic logic [32:0] fake_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        nx;
    if (x == 32'h3f800000 && y == 32'h40000000) return {1'b0, 32'h40400000};
    if (x == 32'h40400000 && y == 32'hbf800000) return {1'b0, 32'h40000000};
    if (x == 32'h3f800000 && y == 32'h33a00000) return {1'b1, 32'h3f800000};
    r = {x[31] ^ y[31], x[30:23] + y[30:23], x[22:0] ^ y[22:0]};
    if (x[1:0] == 2'b11) r[30:23] = 8'h00;
    nx = ^(x[7:0] & y[7:0]);
    return {nx, r};
  endfunction

  assign {fadd_inexact, fadd_out} = fake_add(fadd_in1, fadd_in2);

  // Expected {flags, data} for one request, straight from the screening and flush rules.
  function automatic logic [36:0] ref_op(input logic op, input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b, r;
    logic [32:0] s;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    a = a_in;
    b = b_in;
    if (op) b[31] = ~b[31];
    a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'h0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'h0);
    if (a_nan || b_nan) return {(a_snan || b_snan), 4'b0000, 32'h7fc00000};
    if (a_inf && b_inf && (a[31] != b[31])) return {5'b10000, 32'h7fc00000};
    if (a_inf) return {5'b00000, a[31], 8'hff, 23'h0};
    if (b_inf) return {5'b00000, b[31], 8'hff, 23'h0};
    if (a[30:23] == 8'h00) a = {a[31], 31'h0};
    if (b[30:23] == 8'h00) b = {b[31], 31'h0};
    s = fake_add(a, b);
    r = s[31:0];
    if (r[30:23] == 8'h00) r = {r[31], 31'h0};
    return {4'b0000, s[32], r};
  endfunction

  function automatic logic [31:0] rand_fp();
    int          k = $urandom_range(0, 11);
    logic        s = 1'($urandom);
    logic [22:0] f = 23'($urandom);
    case (k)
      0:       return {s, 31'h0};
      1:       return {s, 8'h00, f | 23'h1};
      2:       return {s, 8'hff, 23'h0};
      3:       return {s, 8'hff, 1'b1, f[21:0]};
      4:       return {s, 8'hff, 1'b0, f[21:0] | 22'h1};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Monitor: scoreboard push on accept, pop and compare on retire, sticky-flag model.
  always @(negedge CLK) begin
    if (!RSTn) begin
      exp_q.delete();
      acc_m = '0;
    end else begin
      ret_f = '0;
      chk("fflags_acc", 64'(fflags_acc), 64'(acc_m));
      if (bus.req_valid && bus.req_ready)
        exp_q.push_back({ref_op(bus.req_op, bus.req_rs1, bus.req_rs2), bus.req_rd});
      if (bus.wb_valid && bus.wb_ready) begin
        chk("wb_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wb_data",  64'(bus.wb_data),  64'(mon_e[36:5]));
          chk("wb_rd",    64'(bus.wb_rd),    64'(mon_e[4:0]));
          chk("wb_flags", 64'(bus.wb_flags), 64'(mon_e[41:37]));
          ret_f = mon_e[41:37];
          n_ret++;
        end
      end
      if (ACC_ON && fflags_clr) acc_m = '0;
      else if (ACC_ON)          acc_m = acc_m | ret_f;
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rand_en) begin
        bus.wb_ready = ($urandom_range(0, 3) != 0);
        fflags_clr   = ($urandom_range(0, 15) == 0);
      end
    end
  end

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_rd    = rd;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge CLK);
      ok = bus.req_ready;
      @(posedge CLK);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!ok) chk("send_accept", 64'(ok), 64'(1));
  endtask

  task automatic run1(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] want_d, input logic [4:0] want_f);
    send(op, a, b, rd);
    chk({tag, "_early"}, 64'(bus.wb_valid), 64'(0));
    @(posedge CLK);
    #1;
    chk({tag, "_valid"}, 64'(bus.wb_valid), 64'(1));
    chk({tag, "_data"},  64'(bus.wb_data),  64'(want_d));
    chk({tag, "_flags"}, 64'(bus.wb_flags), 64'(want_f));
  endtask

  task automatic pulse_clr();
    fflags_clr = 1'b1;
    @(posedge CLK);
    #1;
    fflags_clr = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || bus.wb_valid) && k < 60) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_rd    = '0;
    bus.wb_ready  = 1'b0;
    fflags_clr    = 1'b0;
    RSTn          = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ready",  64'(bus.req_ready), 64'(1));
    chk("rst_wb_valid",   64'(bus.wb_valid),  64'(0));
    chk("rst_wb_data",    64'(bus.wb_data),   64'(0));
    chk("rst_wb_rd",      64'(bus.wb_rd),     64'(0));
    chk("rst_wb_flags",   64'(bus.wb_flags),  64'(0));
    chk("rst_fadd_in1",   64'(fadd_in1),      64'(0));
    chk("rst_fadd_in2",   64'(fadd_in2),      64'(0));
    chk("rst_fflags_acc", 64'(fflags_acc),    64'(0));
    RSTn = 1'b1;
    bus.wb_ready = 1'b1;

    run1("add_1_2",       1'b0, 32'h3f800000, 32'h40000000, 5'd1, 32'h40400000, 5'h00);
    run1("sub_3_1",       1'b1, 32'h40400000, 32'h3f800000, 5'd2, 32'h40000000, 5'h00);
    run1("inf_minus_inf", 1'b0, 32'h7f800000, 32'hff800000, 5'd3, 32'h7fc00000, 5'h10);
    run1("inf_plus_one",  1'b0, 32'h7f800000, 32'h3f800000, 5'd4, 32'h7f800000, 5'h00);
    run1("snan_in",       1'b0, 32'h7f800001, 32'h3f800000, 5'd5, 32'h7fc00000, 5'h10);
    run1("qnan_in",       1'b0, 32'h7fc00001, 32'h3f800000, 5'd6, 32'h7fc00000, 5'h00);
    run1("inf_sub_inf",   1'b1, 32'h7f800000, 32'h7f800000, 5'd7, 32'h7fc00000, 5'h10);
    run1("sub_flush",     1'b0, 32'h00000001, 32'h3f800000, 5'd8, 32'h3f800000, 5'h00);
    pulse_clr();
    chk("acc_cleared", 64'(fflags_acc), 64'(0));

    run1("inexact",       1'b0, 32'h3f800000, 32'h33a00000, 5'd9,  32'h3f800000, 5'h01);
    run1("clean_add",     1'b0, 32'h3f800000, 32'h40000000, 5'd10, 32'h40400000, 5'h00);
    run1("clean_sub",     1'b1, 32'h40400000, 32'h3f800000, 5'd11, 32'h40000000, 5'h00);
    chk("acc_sticky", 64'(fflags_acc), 64'(ACC_ON ? 5'h01 : 5'h00));
    pulse_clr();
    chk("acc_clr", 64'(fflags_acc), 64'(0));
    run1("inexact2",      1'b0, 32'h3f800000, 32'h33a00000, 5'd12, 32'h3f800000, 5'h01);
    pulse_clr();
    chk("acc_clr_prio", 64'(fflags_acc), 64'(0));

    base = n_ret;
    bus.wb_ready = 1'b0;
    send(1'b0, 32'h3f800000, 32'h40000000, 5'd13);
    send(1'b1, 32'h40400000, 32'h3f800000, 5'd14);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_rs1   = 32'h7f800000;
    bus.req_rs2   = 32'h3f800000;
    bus.req_rd    = 5'd15;
    repeat (3) begin
      @(negedge CLK);
      chk("stall_req_ready", 64'(bus.req_ready), 64'(0));
      @(posedge CLK);
      #1;
    end
    chk("stall_wb_valid", 64'(bus.wb_valid), 64'(1));
    chk("stall_wb_rd",    64'(bus.wb_rd),    64'(13));
    chk("stall_wb_data",  64'(bus.wb_data),  64'(32'h40400000));
    bus.wb_ready = 1'b1;
    send(1'b0, 32'h7f800000, 32'h3f800000, 5'd15);
    drain();
    chk("stall_retired", 64'(n_ret - base), 64'(3));

    bus.wb_ready = 1'b0;
    send(1'b0, 32'h3f800000, 32'h40000000, 5'd16);
    send(1'b0, 32'h7f800001, 32'h3f800000, 5'd17);
    #2;
    RSTn = 1'b0;
    #1;
    chk("rst_mid_wb_valid",  64'(bus.wb_valid),  64'(0));
    chk("rst_mid_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_mid_wb_data",   64'(bus.wb_data),   64'(0));
    chk("rst_mid_fadd_in1",  64'(fadd_in1),      64'(0));
    chk("rst_mid_acc",       64'(fflags_acc),    64'(0));
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    bus.wb_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("post_rst_wb_valid", 64'(bus.wb_valid), 64'(0));
    run1("post_rst_add", 1'b0, 32'h3f800000, 32'h40000000, 5'd18, 32'h40400000, 5'h00);

    rand_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(1'($urandom), rand_fp(), rand_fp(), 5'(i));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #1;
      end
    end
    rand_en = 1'b0;
    @(posedge CLK);
    #2;
    bus.wb_ready = 1'b1;
    fflags_clr   = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_stage.md
# fpu_addsub_stage

Pipelined issue/writeback wrapper that sits directly upstream of the combinational single-precision adder, `FADD_F`, and consumes its result. It accepts FADD.S/FSUB.S requests over a valid/ready handshake and registers the operands. It screens NaN, infinity and subnormal cases that the adder does not handle, drives the adder from the operand register, and captures result plus RISC-V fflags into a writeback register. Sits between the FP decode/regfile-read stage and FP writeback.

## Interface
- No parameters; widths fixed (32-bit binary32, 5-bit rd, 5-bit fflags ordered NV,DZ,OF,UF,NX = bits 4..0).
- CLK  in  1  clock; all state on rising edge
- RSTn  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  stage can accept
- req_op  in  1  0 = add, 1 = sub
- req_rs1, req_rs2  in  32  operands
- req_rd  in  5  destination tag, passed through
- fadd_in1, fadd_in2  out  32  registered operands to adder
- fadd_out  in  32  adder result
- fadd_inexact  in  1  adder inexact
- wb_valid  out  1  result present
- wb_ready  in  1  writeback consumes
- wb_data  out  32  result
- wb_rd  out  5  destination tag
- wb_flags  out  5  per-op fflags
- fflags_clr  in  1  clear sticky accumulator
- fflags_acc  out  5  sticky OR of all retired wb_flags

## Operation
- **S1 (operand register).** Loaded on `req_valid & req_ready`.
  - Stores rs1 and rs2. For sub, bit 31 of rs2 is inverted.
  - Subnormal inputs (exp = 0, frac ≠ 0) are flushed to signed zero.
  - Stores rd and a 2-bit special class:
    - NONE
    - QNAN_OUT: NV computed
    - INF_OUT: sign stored
- **Special screening (combinational on request, registered into S1).**
  - Either operand NaN (exp = 0xff, frac ≠ 0) → result 0x7fc00000. NV = 1 iff either is signaling (frac[22] = 0).
  - +inf with -inf (after sub sign flip) → 0x7fc00000, NV = 1.
  - One or both inf with the same sign → {sign, 0xff, 0}, flags 0.
  - Otherwise NONE.
- **S2 (writeback register).** Loaded from S1 when S1 is valid and advancing.
  - Class NONE: wb_data = fadd_out, flushed to {fadd_out[31], 31'b0} if exp = 0. wb_flags = {4'b0, fadd_inexact}.
  - Other classes: the screened value and flags.
- **Advance rules.**
  - s2_adv = ~s2_valid | wb_ready
  - s1_adv = s1_valid & s2_adv
  - req_ready = ~s1_valid | s2_adv
- **Retire.** On `wb_valid & wb_ready`, wb_flags is ORed into fflags_acc.
  - fflags_clr has priority over a same-cycle retire OR; that cycle's flags are lost.
- Requests retire strictly in order. No drop, no duplicate.

## Timing
- Latency is 2 cycles: a request accepted at edge N appears on wb_valid after edge N+1 (S2 loaded at N+1).
- Throughput is 1 per cycle while wb_ready = 1.
- With wb_ready = 0: at most 2 requests held (S1 + S2), and req_ready falls once both are full.
- wb_data, wb_rd and wb_flags are stable while `wb_valid & ~wb_ready`.
- The adder path is S1 reg → FADD_F → S2 reg, as a single-cycle combinational path.
- **Reset (RSTn low, at any time including mid-operation).**
  - s1_valid = s2_valid = 0, so wb_valid = 0.
  - req_ready = 1 after reset.
  - fadd_in1 = fadd_in2 = 0, wb_data = 0, wb_rd = 0, wb_flags = 0, fflags_acc = 0.
  - In-flight requests are discarded.

## Configuration
- `FPU_FFLAGS_ACC_EN`
  - Defined: fflags_acc register and fflags_clr logic are present as above.
  - Undefined: fflags_acc is tied to 0, fflags_clr is ignored, and no accumulator flops exist. wb_flags is unaffected.

## Structure
- Shared FPU package holds:
  - class enum (NONE, QNAN_OUT, INF_OUT)
  - constants FP32_CANON_NAN = 0x7fc00000 and FP32_EXP_MAX = 0xff
  - fflags bit-index constants
- One sub-module, `fp32_classify`: combinational. Takes a 32-bit operand and returns is_zero, is_sub, is_inf, is_nan, is_snan. Instantiated twice.
- FADD_F is instantiated by the parent, not inside this block.

## Test plan
- 0x3f800000 + 0x40000000, wb_ready = 1 → wb_data 0x40400000, wb_flags 0, wb_valid exactly 2 cycles after accept.
- sub 0x40400000, 0x3f800000 → 0x40000000, flags 0.
- 0x7f800000 + 0xff800000 → 0x7fc00000, flags 5'b10000. Also 0x7f800000 + 0x3f800000 → 0x7f800000, flags 0.
- 0x7f800001 + 0x3f800000 → 0x7fc00000, NV set. 0x7fc00001 + 0x3f800000 → 0x7fc00000, flags 0.
- 1.0 + 0x33a00000 → 0x3f800000 with NX = 1. fflags_acc holds 5'b00001 across later clean ops until fflags_clr pulses, then reads 0.
- wb_ready held 0 for 5 cycles while 3 requests are offered:
  - First two are accepted, then req_ready = 0.
  - After release, results retire in order with no loss.
  - Asserting RSTn low mid-stream clears wb_valid immediately.
